// File: rtl/column_compressor_pkg.sv
// Shared sizing for the squarer column compressor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package column_compressor_pkg;

   localparam int N_COLS = 10;   // input columns, weights 2^0..2^9
   localparam int COL_H  = 10;   // equal-weight bits per column
   localparam int OUT_W  = 14;   // holds 10 * (2^10 - 1) = 10230

   typedef logic [COL_H-1:0] col_t;

endpackage

// File: rtl/column_compressor_full_adder_32.sv
// 3:2 counter: three equal-weight bits in, sum bit and next-weight carry out.
// Latency: combinational.
// Backpressure: none.
module full_adder_32 (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/column_compressor.sv
// Sums 10 columns x 10 equal-weight bits (column i weight 2^i) into a 14-bit registered result.
// Latency: 1 cycle; 2 cycles when COMPRESSOR_PIPE2_EN is defined (register between tree and final adder).
// Backpressure: none; a new input set is accepted every cycle.
module column_compressor
   import column_compressor_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [COL_H-1:0] src0,
   input  logic [COL_H-1:0] src1,
   input  logic [COL_H-1:0] src2,
   input  logic [COL_H-1:0] src3,
   input  logic [COL_H-1:0] src4,
   input  logic [COL_H-1:0] src5,
   input  logic [COL_H-1:0] src6,
   input  logic [COL_H-1:0] src7,
   input  logic [COL_H-1:0] src8,
   input  logic [COL_H-1:0] src9,
   output logic             dst0,
   output logic             dst1,
   output logic             dst2,
   output logic             dst3,
   output logic             dst4,
   output logic             dst5,
   output logic             dst6,
   output logic             dst7,
   output logic             dst8,
   output logic             dst9,
   output logic             dst10,
   output logic             dst11,
   output logic             dst12,
   output logic             dst13
);

   // Eight 3:2 levels fold ten rows down to one sum row and one carry row.
   localparam int N_STG = COL_H - 2;

   col_t             cols [N_COLS];
   logic [OUT_W-1:0] rows [COL_H];
   logic [OUT_W-1:0] cs_sum;
   logic [OUT_W-1:0] cs_car;
   logic [OUT_W-1:0] final_sum;
   logic [OUT_W-1:0] res_q;

   assign cols[0] = src0;
   assign cols[1] = src1;
   assign cols[2] = src2;
   assign cols[3] = src3;
   assign cols[4] = src4;
   assign cols[5] = src5;
   assign cols[6] = src6;
   assign cols[7] = src7;
   assign cols[8] = src8;
   assign cols[9] = src9;

   // Transpose columns into rows: row j takes bit j of every column, so each row is a plain binary number.
   always_comb begin
      for (int j = 0; j < COL_H; j++) begin
         rows[j] = '0;
         for (int i = 0; i < N_COLS; i++) begin
            rows[j][i] = cols[i][j];
         end
      end
   end

   // Carry-save array: each level adds one more row into the running (sum, carry) pair.
   for (genvar j = 0; j < N_STG; j++) begin : g_stg
      logic [OUT_W-1:0] a_v;
      logic [OUT_W-1:0] b_v;
      logic [OUT_W-1:0] s_v;
      logic [OUT_W-1:0] c_v;

      if (j == 0) begin : g_first
         assign a_v = rows[0];
         assign b_v = rows[1];
      end else begin : g_next
         assign a_v = g_stg[j-1].s_v;
         assign b_v = g_stg[j-1].c_v;
      end

      // Nothing carries into weight 2^0.
      assign c_v[0] = 1'b0;

      for (genvar k = 0; k < OUT_W-1; k++) begin : g_bit
         full_adder_32 u_fa (
            .a  (a_v[k]),
            .b  (b_v[k]),
            .c  (rows[j+2][k]),
            .s  (s_v[k]),
            .co (c_v[k+1])
         );
      end

      // Top column: a carry here would mean a sum >= 2^14, which cannot occur, so only the sum bit is kept.
      assign s_v[OUT_W-1] = a_v[OUT_W-1] ^ b_v[OUT_W-1] ^ rows[j+2][OUT_W-1];
   end

   assign cs_sum = g_stg[N_STG-1].s_v;
   assign cs_car = g_stg[N_STG-1].c_v;

`ifdef COMPRESSOR_PIPE2_EN
   logic [OUT_W-1:0] sum_q;
   logic [OUT_W-1:0] car_q;

   // Split point: hold the two carry-save rows before the carry-propagate adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         car_q <= '0;
      end else begin
         sum_q <= cs_sum;
         car_q <= cs_car;
      end
   end

   assign final_sum = sum_q + car_q;
`else
   assign final_sum = cs_sum + cs_car;
`endif

   // Result register, captured every cycle; async clear drops any in-flight result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else begin
         res_q <= final_sum;
      end
   end

   assign dst0  = res_q[0];
   assign dst1  = res_q[1];
   assign dst2  = res_q[2];
   assign dst3  = res_q[3];
   assign dst4  = res_q[4];
   assign dst5  = res_q[5];
   assign dst6  = res_q[6];
   assign dst7  = res_q[7];
   assign dst8  = res_q[8];
   assign dst9  = res_q[9];
   assign dst10 = res_q[10];
   assign dst11 = res_q[11];
   assign dst12 = res_q[12];
   assign dst13 = res_q[13];

endmodule

// File: tb/tb_column_compressor.sv
// Self-checking bench for column_compressor: directed table, random back-to-back stream, async reset mid-stream.
// Latency: follows COMPRESSOR_PIPE2_EN (1 or 2 cycles).
// Backpressure: none exercised (design has none).
module tb_column_compressor;

`ifdef COMPRESSOR_PIPE2_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  src [10];
   wire  [13:0] dst_v;

   int total = 0;
   int bad   = 0;

   logic [13:0] exp_q [$];
   string       name_q [$];

   typedef struct {
      logic [99:0] v;
      logic [13:0] e;
      string       name;
   } vec_t;

   vec_t tbl [7];

   always #5 clk = ~clk;

   column_compressor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .src0  (src[0]), .src1 (src[1]), .src2 (src[2]), .src3 (src[3]), .src4 (src[4]),
      .src5  (src[5]), .src6 (src[6]), .src7 (src[7]), .src8 (src[8]), .src9 (src[9]),
      .dst0  (dst_v[0]),  .dst1  (dst_v[1]),  .dst2  (dst_v[2]),  .dst3  (dst_v[3]),
      .dst4  (dst_v[4]),  .dst5  (dst_v[5]),  .dst6  (dst_v[6]),  .dst7  (dst_v[7]),
      .dst8  (dst_v[8]),  .dst9  (dst_v[9]),  .dst10 (dst_v[10]), .dst11 (dst_v[11]),
      .dst12 (dst_v[12]), .dst13 (dst_v[13])
   );

   // Reference: sum over columns of popcount(column) * 2^i.
   function automatic logic [13:0] ref_sum(input logic [99:0] v);
      int r = 0;
      for (int i = 0; i < 10; i++) begin
         r += $countones(v[i*10 +: 10]) * (1 << i);
      end
      return 14'(r);
   endfunction

   function automatic logic [99:0] col(input int i, input logic [9:0] b);
      logic [99:0] t;
      t = {90'b0, b};
      return t << (i * 10);
   endfunction

   task automatic check(input string name, input logic [13:0] got, input logic [13:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=0x%h want=0x%h", name, got, req);
      end
   endtask

   task automatic apply(input logic [99:0] v);
      for (int i = 0; i < 10; i++) src[i] = v[i*10 +: 10];
   endtask

   // One cycle: check the result due now, then drive the next vector.
   task automatic step(input logic [99:0] v, input logic [13:0] e, input string name);
      @(negedge clk);
      if (exp_q.size() >= LAT) check(name_q.pop_front(), dst_v, exp_q.pop_front());
      apply(v);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   // Release reset with a live vector; pipeline stages behind it read as zero.
   task automatic release_rst(input logic [99:0] v);
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      name_q.delete();
      for (int i = 0; i < LAT-1; i++) begin
         exp_q.push_back(14'h0);
         name_q.push_back("post_rst_zero");
      end
      apply(v);
      exp_q.push_back(ref_sum(v));
      name_q.push_back("post_rst_first");
   endtask

   task automatic random_run(input int n);
      logic [99:0] v;
      for (int k = 0; k < n; k++) begin
         v = {$urandom, $urandom, $urandom, $urandom};
         case ($urandom_range(0, 3))
            0: for (int i = 0; i < 10; i++) if ($urandom_range(0, 1) == 1) v[i*10 +: 10] = 10'h3FF;
            1: for (int i = 0; i < 10; i++) if ($urandom_range(0, 1) == 1) v[i*10 +: 10] = 10'h000;
            default: ;
         endcase
         step(v, ref_sum(v), "random");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [99:0] one_each;
      one_each = '0;
      for (int i = 0; i < 10; i++) one_each |= col(i, 10'(1 << i));

      tbl[0] = '{'0,                                    14'h0000, "all_zero"};
      tbl[1] = '{col(0, 10'h3FF),                       14'd10,   "src0_full"};
      tbl[2] = '{col(9, 10'h001),                       14'd512,  "src9_lsb"};
      tbl[3] = '{{10{10'h3FF}},                         14'h27F6, "all_full"};
      tbl[4] = '{col(5, 10'h3FF) | col(0, 10'h200),     14'd321,  "src5_full_src0_bit"};
      tbl[5] = '{col(9, 10'h3FF),                       14'd5120, "src9_full"};
      tbl[6] = '{one_each,                              14'd1023, "one_bit_each"};

      // Reset state with all inputs driven high.
      rst_n = 1'b1;
      apply({10{10'h3FF}});
      #1 rst_n = 1'b0;
      #1 check("reset_async", dst_v, 14'h0);
      repeat (2) @(posedge clk);
      #1 check("reset_hold", dst_v, 14'h0);

      release_rst(col(3, 10'h155));

      // Directed vectors, back to back.
      for (int t = 0; t < 7; t++) step(tbl[t].v, tbl[t].e, tbl[t].name);

      random_run(200);

      // Mid-stream reset: output must clear without a clock edge.
      for (int t = 0; t < LAT + 1; t++) step({10{10'h3FF}}, 14'h27F6, "pre_rst_stream");
      #2 check("pre_rst_value", dst_v, 14'h27F6);
      rst_n = 1'b0;
      #1 check("midstream_async_clear", dst_v, 14'h0);
      @(posedge clk);
      #1 check("midstream_hold", dst_v, 14'h0);

      release_rst({10{10'h2AA}});
      random_run(100);

      // Drain results still in flight.
      for (int t = 0; t < LAT; t++) step('0, 14'h0, "drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
